// File: rtl/mac_pkg.sv
// Shared definitions for the 16x16->32 MAC pipeline and its upstream sequencer.
//   MAC_ADD_LAT : cycles from mac_a/mac_b valid to the adder cycle that reads acc_in
//   MAC_OUT_LAT : cycles from mac_a/mac_b valid to acc_out valid
//   OP_W/ACC_W  : operand and accumulator widths
//   mac_tag_t   : per-issue tag travelling alongside the operands
//   seq_state_t : sequencer FSM states
package mac_pkg;

    localparam int unsigned MAC_ADD_LAT = 3;
    localparam int unsigned MAC_OUT_LAT = 5;
    localparam int unsigned OP_W        = 16;
    localparam int unsigned ACC_W       = 32;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mac_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Tag shift register that tracks each issue through the MAC pipeline.
// Depth 0 is aligned with the registered mac_a/mac_b outputs.
//   clk, rst   : clock, asynchronous active-high reset
//   tag_in     : tag for the issue launched this cycle (all-zero for a bubble)
//   add_first  : tag at depth ADD_LAT is a valid first element (MAC must add 0)
//   out_last   : tag at depth OUT_LAT is a valid last element (acc_out holds the result)
module mac_tag_pipe
    import mac_pkg::*;
#(
    parameter int unsigned ADD_LAT = MAC_ADD_LAT,
    parameter int unsigned OUT_LAT = MAC_OUT_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  mac_tag_t tag_in,
    output logic     add_first,
    output logic     out_last
);

    // Depths 0..ADD_LAT carry the full tag; past the adder only "valid last"
    // is still needed, so the tail segment is reduced to a single bit per depth.
    mac_tag_t [ADD_LAT:0]         head;
    logic     [OUT_LAT-ADD_LAT-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            head[0] <= tag_in;
            for (int unsigned i = 1; i <= ADD_LAT; i++) begin
                head[i] <= head[i-1];
            end
            tail[0] <= head[ADD_LAT].valid && head[ADD_LAT].last;
            for (int unsigned i = 1; i < OUT_LAT - ADD_LAT; i++) begin
                tail[i] <= tail[i-1];
            end
        end
    end

    assign add_first = head[ADD_LAT].valid && head[ADD_LAT].first;
    assign out_last  = tail[OUT_LAT-ADD_LAT-1];

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer and accumulator-feedback controller for the MAC pipeline.
// Issues one operand pair every other cycle (single interleave slot of the
// MAC's 2-deep adder loop), steers acc_in so products accumulate inside the
// MAC, and returns the final sum as a one-cycle result pulse.
//   clk, rst     : clock, asynchronous active-high reset (also resets the MAC)
//   start, len   : job request and number of operand pairs (sampled in IDLE)
//   op_valid/op_ready, op_a, op_b : operand pair handshake
//   mac_a, mac_b : registered operands to the MAC
//   mac_acc_in   : accumulator feed to the MAC (combinational)
//   mac_acc_out  : accumulator result from the MAC
//   res_valid    : one-cycle result pulse; res_data holds until the next result
//   busy         : a job is in progress
module mac_dot_seq #(
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned MAC_ADD_LAT = mac_pkg::MAC_ADD_LAT,
    parameter int unsigned MAC_OUT_LAT = mac_pkg::MAC_OUT_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [mac_pkg::OP_W-1:0]  op_a,
    input  logic [mac_pkg::OP_W-1:0]  op_b,
    output logic [mac_pkg::OP_W-1:0]  mac_a,
    output logic [mac_pkg::OP_W-1:0]  mac_b,
    output logic [mac_pkg::ACC_W-1:0] mac_acc_in,
    input  logic [mac_pkg::ACC_W-1:0] mac_acc_out,
    output logic                      res_valid,
    output logic [mac_pkg::ACC_W-1:0] res_data,
    output logic                      busy
);

    import mac_pkg::*;

    seq_state_t       state, state_nx;
    logic             slot;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_q;
    logic             fire;
    logic             add_first;
    logic             out_last;
    mac_tag_t         tag_in;

    assign busy     = (state != ST_IDLE);
    assign op_ready = (state == ST_RUN) && slot && (remaining != '0);
    assign fire     = op_valid && op_ready;

    always_comb begin
        tag_in = '0;
        if (fire) begin
            tag_in.valid = 1'b1;
            tag_in.first = (remaining == len_q);
            tag_in.last  = (remaining == LEN_W'(1));
        end
    end

    mac_tag_pipe #(
        .ADD_LAT(MAC_ADD_LAT),
        .OUT_LAT(MAC_OUT_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (tag_in),
        .add_first(add_first),
        .out_last (out_last)
    );

    // Bubbles feed acc_out straight back with a zero product, so the partial
    // sum simply recirculates; only a job's first element breaks the loop.
    assign mac_acc_in = add_first ? '0 : mac_acc_out;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start && (len != '0))               state_nx = ST_RUN;
            ST_RUN:   if (fire && (remaining == LEN_W'(1)))   state_nx = ST_DRAIN;
            ST_DRAIN: if (out_last)                           state_nx = ST_IDLE;
            default:                                          state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= 1'b0;
            remaining <= '0;
            len_q     <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            remaining <= len;
                            len_q     <= len;
                            slot      <= 1'b1;
                        end else begin
                            res_valid <= 1'b1;
                            res_data  <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    slot <= ~slot;
                    if (fire) begin
                        mac_a     <= op_a;
                        mac_b     <= op_b;
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_last) begin
                        res_valid <= 1'b1;
                        res_data  <= mac_acc_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
`timescale 1ns/1ps
module tb_mac_dot_seq;

    typedef struct packed {
        logic [7:0]        len;
        logic [3:0][15:0]  a;
        logic [3:0][15:0]  b;
        logic [3:0]        gap;
        logic [31:0]       exp;
    } vec_t;

    localparam int NV = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len_i = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] mac_a, mac_b;
    logic [31:0] mac_acc_in, mac_acc_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        prev_ready = 1'b0;
    logic [31:0] exp_q[$];
    vec_t        vecs[NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_dot_seq #(
        .LEN_W(8),
        .MAC_ADD_LAT(3),
        .MAC_OUT_LAT(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len_i),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_acc_in (mac_acc_in),
        .mac_acc_out(mac_acc_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy)
    );

    // MAC model: product ready 3 cycles after a/b, adder reads acc_in then,
    // acc_out follows 2 cycles later.
    logic [31:0] prod_q[3];
    logic [31:0] sum_q, acc_out_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q[0] <= '0; prod_q[1] <= '0; prod_q[2] <= '0;
            sum_q <= '0; acc_out_q <= '0;
        end else begin
            prod_q[0] <= 32'(mac_a) * 32'(mac_b);
            prod_q[1] <= prod_q[0];
            prod_q[2] <= prod_q[1];
            sum_q     <= prod_q[2] + mac_acc_in;
            acc_out_q <= sum_q;
        end
    end
    assign mac_acc_out = acc_out_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every result pulse is matched against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_ready = 1'b0;
        end else begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got pulse with 0x%08h, expected no pulse (cycle %0d)", res_data, cyc);
                end else begin
                    check("res_data", res_data, exp_q.pop_front());
                end
            end
            if (op_ready) check("op_ready_phase", {31'b0, prev_ready}, 32'd0);
            prev_ready = op_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len_i = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int gap, output int fire_cyc);
        op_valid = 1'b0;
        repeat (gap) begin
            tick();
            check("mac_a_bubble", {16'b0, mac_a}, 32'd0);
        end
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        fire_cyc = -1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (op_ready) begin
                fire_cyc = cyc;
                tick();
                check("mac_a", {16'b0, mac_a}, {16'b0, a});
                check("mac_b", {16'b0, mac_b}, {16'b0, b});
                break;
            end
            tick();
            check("mac_a_stall", {16'b0, mac_a}, 32'd0);
        end
        op_valid = 1'b0;
        if (fire_cyc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL fire_timeout: got no op_ready in 16 cycles, expected a fire");
        end
    endtask

    task automatic wait_result(output int rc);
        rc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (res_valid) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL result_timeout: got no res_valid in 40 cycles, expected a pulse");
        end
    endtask

    task automatic after_result(input logic [31:0] exp);
        check("busy_at_result", {31'b0, busy}, 32'd0);
        tick();
        @(negedge clk);
        check("res_pulse_width", {31'b0, res_valid}, 32'd0);
        check("busy_after", {31'b0, busy}, 32'd0);
        check("res_data_held", res_data, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, pf, rc;
        logic [31:0] e;

        vecs[0] = '{8'd3, {16'd0, 16'd3, 16'd2, 16'd1}, {16'd0, 16'd6, 16'd5, 16'd4}, 4'd0, 32'd32};
        vecs[1] = '{8'd3, {16'd0, 16'd3, 16'd2, 16'd1}, {16'd0, 16'd6, 16'd5, 16'd4}, 4'd3, 32'd32};
        vecs[2] = '{8'd2, {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, 4'd0, 32'hFFFC0002};
        vecs[3] = '{8'd0, 64'd0, 64'd0, 4'd0, 32'd0};
        vecs[4] = '{8'd4, {16'd70, 16'd50, 16'd30, 16'd10}, {16'd80, 16'd60, 16'd40, 16'd20}, 4'd1, 32'd10000};
        vecs[5] = '{8'd1, {16'd0, 16'd0, 16'd0, 16'hFFFF}, {16'd0, 16'd0, 16'd0, 16'd1}, 4'd2, 32'h0000FFFF};
        vecs[6] = '{8'd4, {4{16'h8000}}, {4{16'h8000}}, 4'd0, 32'd0};

        // Reset state, with a start request held during reset.
        start = 1'b1;
        len_i = 8'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mac_a", {16'b0, mac_a}, 32'd0);
        check("rst_mac_b", {16'b0, mac_b}, 32'd0);
        check("rst_acc_in", mac_acc_in, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_op_ready", {31'b0, op_ready}, 32'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < NV; v++) begin
            if (vecs[v].len == 8'd0) begin
                exp_q.push_back(vecs[v].exp);
                start = 1'b1;
                len_i = 8'd0;
                @(negedge clk);
                check("empty_busy0", {31'b0, busy}, 32'd0);
                tick();
                start = 1'b0;
                @(negedge clk);
                check("empty_res_valid", {31'b0, res_valid}, 32'd1);
                check("empty_busy1", {31'b0, busy}, 32'd0);
                after_result(vecs[v].exp);
            end else begin
                exp_q.push_back(vecs[v].exp);
                start_job(vecs[v].len);
                pf = -1;
                for (int k = 0; k < int'(vecs[v].len); k++) begin
                    send_pair(vecs[v].a[k], vecs[v].b[k], (k == 0) ? 0 : int'(vecs[v].gap), f);
                    if (pf >= 0 && vecs[v].gap == 4'd0) check("fire_spacing", f - pf, 32'd2);
                    if (pf >= 0 && vecs[v].gap != 4'd0) check("fire_parity", (f - pf) % 2, 32'd0);
                    pf = f;
                end
                wait_result(rc);
                check("latency", rc - pf, 32'd7);
                after_result(vecs[v].exp);
            end
        end

        // Back-to-back: new job started in the result cycle must not inherit 32.
        exp_q.push_back(32'd32);
        start_job(8'd3);
        send_pair(16'd1, 16'd4, 0, f);
        send_pair(16'd2, 16'd5, 0, f);
        send_pair(16'd3, 16'd6, 0, f);
        wait_result(rc);
        check("b2b_busy_at_result", {31'b0, busy}, 32'd0);
        start = 1'b1;
        len_i = 8'd1;
        op_a = 16'h0100;
        op_b = 16'h0100;
        op_valid = 1'b1;
        exp_q.push_back(32'h00010000);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("b2b_ready", {31'b0, op_ready}, 32'd1);
        f = cyc;
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("b2b_acc_in_zero", mac_acc_in, 32'd0);
        check("b2b_stale_sum", mac_acc_out, 32'd32);
        wait_result(rc);
        check("b2b_latency", rc - f, 32'd7);
        after_result(32'h00010000);

        // Reset after one of three pairs: no pulse, then a clean job.
        start_job(8'd3);
        send_pair(16'd1, 16'd4, 0, f);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_op_ready", {31'b0, op_ready}, 32'd0);
        check("midrst_res_data", res_data, 32'd0);
        tick();
        rst = 1'b0;
        repeat (12) tick();
        exp_q.push_back(32'd63);
        start_job(8'd1);
        send_pair(16'd7, 16'd9, 0, f);
        wait_result(rc);
        check("midrst_latency", rc - f, 32'd7);
        after_result(32'd63);

        // Maximum length, with start requests issued while busy.
        e = '0;
        for (int k = 0; k < 255; k++) e += 32'(k + 1) * 32'd3;
        exp_q.push_back(e);
        start_job(8'd255);
        for (int k = 0; k < 255; k++) begin
            if (k == 10) begin
                start = 1'b1;
                len_i = 8'd5;
            end
            if (k == 13) start = 1'b0;
            send_pair(16'(k + 1), 16'd3, 0, f);
        end
        wait_result(rc);
        check("maxlen_latency", rc - f, 32'd7);
        after_result(e);

        repeat (10) tick();
        check("pending_results", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Upstream sequencer and feedback controller for the 16x16->32 MAC pipeline.
- Accepts a dot-product job (vector length) plus a stream of operand pairs over a valid/ready handshake.
- Drives the MAC's a, b and acc_in ports so successive products accumulate through the MAC's own adder.
- Captures the final sum from acc_out and presents it as a one-cycle result pulse.

Parameters:
- LEN_W, 8, width of the vector-length field; max length 2^LEN_W-1.
- MAC_ADD_LAT, 3, cycles from mac_a/mac_b valid to the MAC adder cycle that consumes acc_in.
- MAC_OUT_LAT, 5, cycles from mac_a/mac_b valid to acc_out valid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high; also resets the attached MAC.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs in the job; sampled with start.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand pair accepted this cycle if op_valid.
- op_a  in  16  multiplicand, unsigned.
- op_b  in  16  multiplier, unsigned.
- mac_a  out  16  to MAC a; registered.
- mac_b  out  16  to MAC b; registered.
- mac_acc_in  out  32  to MAC acc_in; combinational from the tag pipe and mac_acc_out.
- mac_acc_out  in  32  from MAC acc_out.
- res_valid  out  1  one-cycle pulse; result available.
- res_data  out  32  dot product modulo 2^32; held until the next result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; tag pipe cleared; slot = 0; remaining = 0.
- Feedback loop: the MAC adder-to-acc_out loop is 2 cycles deep and holds 2 interleaved slots. The job uses the even slot only, so issues are spaced ≥2 cycles apart and always in the same phase.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start && len != 0: go to RUN; remaining <= len; slot <= 1.
  - start && len == 0: next cycle res_valid = 1, res_data = 0; stay in IDLE.
- RUN:
  - slot toggles every cycle.
  - op_ready = slot && remaining != 0.
  - Fire (op_valid && op_ready): next cycle mac_a/mac_b = op_a/op_b; remaining decrements; tag {valid = 1, first = (remaining == len), last = (remaining == 1)} enters the tag pipe.
  - No fire: mac_a/mac_b = 0 next cycle; an invalid tag enters the pipe.
  - When the last fire occurs: go to DRAIN.
- acc_in rule, evaluated every cycle from the tag at depth MAC_ADD_LAT:
  - valid && first: mac_acc_in = 0.
  - Any other case, including invalid/bubble slots: mac_acc_in = mac_acc_out.
  - Effect: on bubbles the zero product recirculates the partial sum, so gaps of any length on op_valid are lossless.
- DRAIN: when the last tag reaches depth MAC_OUT_LAT, capture res_data <= mac_acc_out with res_valid = 1 in the following cycle, then go to IDLE.
- Latency: fire in cycle F gives mac_a valid in F+1, the adder cycle in F+4, acc_out in F+6, and res_valid in F+7 for the last element.
- start while busy: ignored. A new start is accepted in the cycle res_valid is high.
- Arithmetic: unsigned 16x16 products; 32-bit accumulation wraps silently; no overflow flag.
- rst mid-job: the job is aborted immediately with no result pulse; the MAC is cleared by the same rst.
- op_valid held without op_ready: data is not consumed; the source must keep op_a/op_b stable.

Decomposition:
- Shared package mac_pkg holds:
  - MAC_ADD_LAT = 3, MAC_OUT_LAT = 5
  - operand width 16, accumulator width 32
  - tag struct {valid, first, last}
- Sub-module mac_tag_pipe: a MAC_OUT_LAT-deep tag shift register with taps at MAC_ADD_LAT and MAC_OUT_LAT, async-reset.
- Bench instantiates mac_dot_seq wired to the MAC.

Test Plan:
- Basic job: len=3, pairs (1,4), (2,5), (3,6), op_valid always high -> single res_valid with res_data = 32; fires exactly 2 cycles apart; busy low after the pulse.
- Stalls: same job with op_valid low for 3 cycles between pairs -> res_data = 32; op_ready only in slot-phase cycles.
- Wrap-around: len=2, a = b = 0xFFFF both -> res_data = 0xFFFC0002.
- Empty job: len=0 -> res_valid the next cycle, res_data = 0; busy never asserts.
- Reset mid-job: rst after 1 of 3 pairs, then len=1, (7,9) -> no pulse for the aborted job; res_data = 63.
- Back-to-back jobs: start asserted in the res_valid cycle with len=1, (0x100,0x100) -> second result 0x00010000; the first element's acc_in=0 is honoured (no carry-over of 32).
